// File: rtl/ctrl_pkg.sv
// Shared decode constants and the control bundle carried down the
// ID/EX -> EX/MEM -> MEM/WB pipeline of the 5-stage MIPS core.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    typedef struct packed {
        logic       regwr;
        logic       regdst;
        logic       extop;
        logic       alusrc;
        logic       branch;
        logic       bne;
        logic       jump;
        logic       memwr;
        logic       memtoreg;
        logic [2:0] aluctr;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

    // Instructions whose rt field is a source operand (not a destination or unused).
    function automatic logic uses_rt(input ctrl_t c);
        return c.regdst | c.memwr | c.branch;
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// ID-stage instruction fields in, hazard/redirect and per-stage controls out.
interface pipe_ctrl_unit_if #(
    parameter int ALUCTR_W = 3,
    parameter int RA_W     = 5
);
    logic [5:0]          op;
    logic [5:0]          func;
    logic [RA_W-1:0]     id_rs;
    logic [RA_W-1:0]     id_rt;
    logic [RA_W-1:0]     id_rd;
    logic                ex_zero;

    logic                stall;
    logic                ifid_flush;
    logic                jump;
    logic                br_taken;
    logic                ex_alusrc;
    logic [ALUCTR_W-1:0] ex_aluctr;
    logic                ex_extop;
    logic [RA_W-1:0]     ex_waddr;
    logic [1:0]          fwd_a;
    logic [1:0]          fwd_b;
    logic                mem_memwr;
    logic                wb_regwr;
    logic                wb_memtoreg;
    logic [RA_W-1:0]     wb_waddr;

    modport master (
        output op, func, id_rs, id_rt, id_rd, ex_zero,
        input  stall, ifid_flush, jump, br_taken, ex_alusrc, ex_aluctr, ex_extop,
               ex_waddr, fwd_a, fwd_b, mem_memwr, wb_regwr, wb_memtoreg, wb_waddr
    );

    modport slave (
        input  op, func, id_rs, id_rt, id_rd, ex_zero,
        output stall, ifid_flush, jump, br_taken, ex_alusrc, ex_aluctr, ex_extop,
               ex_waddr, fwd_a, fwd_b, mem_memwr, wb_regwr, wb_memtoreg, wb_waddr
    );
endinterface

// File: rtl/ctrl_decode.sv
// Pure combinational op/func decode into the control bundle; anything not
// recognised comes out as a bubble with valid low.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output ctrl_t      ctl,
    output logic       valid
);
    always_comb begin
        ctl   = BUBBLE;
        valid = 1'b1;
        case (op)
            OP_RTYPE: begin
                ctl.regdst = 1'b1;
                ctl.regwr  = 1'b1;
                case (func)
                    FN_ADD:  ctl.aluctr = ALU_ADD;
                    FN_SUB:  ctl.aluctr = ALU_SUB;
                    FN_AND:  ctl.aluctr = ALU_AND;
                    FN_OR:   ctl.aluctr = ALU_OR;
                    FN_SLT:  ctl.aluctr = ALU_SLT;
                    default: begin
                        ctl   = BUBBLE;
                        valid = 1'b0;
                    end
                endcase
            end
            OP_LW: begin
                ctl.regwr    = 1'b1;
                ctl.memtoreg = 1'b1;
                ctl.alusrc   = 1'b1;
                ctl.extop    = 1'b1;
            end
            OP_SW: begin
                ctl.memwr  = 1'b1;
                ctl.alusrc = 1'b1;
                ctl.extop  = 1'b1;
            end
            OP_ADDI: begin
                ctl.regwr  = 1'b1;
                ctl.alusrc = 1'b1;
                ctl.extop  = 1'b1;
            end
            OP_ORI: begin
                ctl.regwr  = 1'b1;
                ctl.alusrc = 1'b1;
                ctl.aluctr = ALU_OR;
            end
            OP_BEQ, OP_BNE: begin
                ctl.branch = 1'b1;
                ctl.bne    = (op == OP_BNE);
                ctl.aluctr = ALU_SUB;
            end
            OP_J:    ctl.jump = 1'b1;
            default: valid = 1'b0;
        endcase
    end
endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control: ID decode, ID/EX-EX/MEM-MEM/WB control registers,
// load-use / RAW stall, branch/jump flush and EX-stage forwarding selects.
module pipe_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int ALUCTR_W = 3,
    parameter int RA_W     = 5,
    parameter bit FWD_EN   = 1'b1
) (
    input logic             clk,
    input logic             rst,
    pipe_ctrl_unit_if.slave bus
);
    typedef struct packed {
        logic            regwr, memwr, memtoreg, extop, alusrc, branch, bne;
        logic [2:0]      aluctr;
        logic [RA_W-1:0] waddr, rs, rt;
    } idex_t;

    typedef struct packed {
        logic            regwr, memwr, memtoreg;
        logic [RA_W-1:0] waddr;
    } exmem_t;

    typedef struct packed {
        logic            regwr, memtoreg;
        logic [RA_W-1:0] waddr;
    } memwb_t;

    idex_t  idex_d,  idex_q;
    exmem_t exmem_d, exmem_q;
    memwb_t memwb_d, memwb_q;

    ctrl_t dec;
    logic  dec_valid;
    logic  rt_used, ex_hit, mem_hit, br_taken, stall, jump;
    logic [1:0] fwd_a, fwd_b;

    ctrl_decode u_dec (.op(bus.op), .func(bus.func), .ctl(dec), .valid(dec_valid));

    // Register 0 is hardwired, so it never produces a hazard or a forward.
    function automatic logic hit(input logic regwr, input logic [RA_W-1:0] waddr, src);
        return regwr && (waddr != '0) && (waddr == src);
    endfunction

    always_comb begin
        rt_used  = uses_rt(dec);
        ex_hit   = hit(idex_q.regwr, idex_q.waddr, bus.id_rs) ||
                   (rt_used && hit(idex_q.regwr, idex_q.waddr, bus.id_rt));
        mem_hit  = hit(exmem_q.regwr, exmem_q.waddr, bus.id_rs) ||
                   (rt_used && hit(exmem_q.regwr, exmem_q.waddr, bus.id_rt));
        br_taken = idex_q.branch & (bus.ex_zero ^ idex_q.bne);
        // Without forwarding, any producer still in EX or MEM must drain first.
        stall    = !br_taken && (FWD_EN ? (ex_hit && idex_q.memtoreg) : (ex_hit || mem_hit));
        jump     = dec.jump && !stall && !br_taken;
    end

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (FWD_EN) begin
            if (hit(exmem_q.regwr, exmem_q.waddr, idex_q.rs))      fwd_a = 2'b10;
            else if (hit(memwb_q.regwr, memwb_q.waddr, idex_q.rs)) fwd_a = 2'b01;
            if (hit(exmem_q.regwr, exmem_q.waddr, idex_q.rt))      fwd_b = 2'b10;
            else if (hit(memwb_q.regwr, memwb_q.waddr, idex_q.rt)) fwd_b = 2'b01;
        end
    end

    always_comb begin
        idex_d = '0;
        // A J is fully handled in ID, so it always continues as a bubble.
        if (!(stall || br_taken || dec.jump || !dec_valid)) begin
            idex_d.regwr    = dec.regwr;
            idex_d.memwr    = dec.memwr;
            idex_d.memtoreg = dec.memtoreg;
            idex_d.extop    = dec.extop;
            idex_d.alusrc   = dec.alusrc;
            idex_d.branch   = dec.branch;
            idex_d.bne      = dec.bne;
            idex_d.aluctr   = dec.aluctr;
            idex_d.waddr    = dec.regdst ? bus.id_rd : bus.id_rt;
            idex_d.rs       = bus.id_rs;
            idex_d.rt       = bus.id_rt;
        end
        exmem_d.regwr    = idex_q.regwr;
        exmem_d.memwr    = idex_q.memwr;
        exmem_d.memtoreg = idex_q.memtoreg;
        exmem_d.waddr    = idex_q.waddr;
        memwb_d.regwr    = exmem_q.regwr;
        memwb_d.memtoreg = exmem_q.memtoreg;
        memwb_d.waddr    = exmem_q.waddr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign bus.stall       = stall;
    assign bus.jump        = jump;
    assign bus.br_taken    = br_taken;
    assign bus.ifid_flush  = br_taken | jump;
    assign bus.ex_alusrc   = idex_q.alusrc;
    assign bus.ex_aluctr   = ALUCTR_W'(idex_q.aluctr);
    assign bus.ex_extop    = idex_q.extop;
    assign bus.ex_waddr    = idex_q.waddr;
    assign bus.fwd_a       = fwd_a;
    assign bus.fwd_b       = fwd_b;
    assign bus.mem_memwr   = exmem_q.memwr;
    assign bus.wb_regwr    = memwb_q.regwr;
    assign bus.wb_memtoreg = memwb_q.memtoreg;
    assign bus.wb_waddr    = memwb_q.waddr;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed cycle-by-cycle vectors for pipe_ctrl_unit (forwarding on), plus a
// short sequence on a second instance with forwarding disabled.
module tb_pipe_ctrl_unit;
    localparam logic [5:0] R = 6'h00, J = 6'h02, BEQ = 6'h04, BNE = 6'h05;
    localparam logic [5:0] ADDI = 6'h08, ORI = 6'h0D, LW = 6'h23, SW = 6'h2B, BAD = 6'h3F;
    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_BAD = 6'h3F;

    typedef struct packed {
        logic       st, fl, jp, bt, as;
        logic [2:0] ac;
        logic       ex;
        logic [4:0] ew;
        logic [1:0] fa, fb;
        logic       mw, wr, wm;
        logic [4:0] ww;
    } out_t;

    typedef struct {
        logic       rst;
        logic [5:0] op, fn;
        logic [4:0] rs, rt, rd;
        logic       z;
        out_t       exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    always #5 clk = ~clk;

    pipe_ctrl_unit_if #(.ALUCTR_W(3), .RA_W(5)) bus1 ();
    pipe_ctrl_unit_if #(.ALUCTR_W(3), .RA_W(5)) bus2 ();

    pipe_ctrl_unit #(.ALUCTR_W(3), .RA_W(5), .FWD_EN(1'b1)) dut  (.clk(clk), .rst(rst),  .bus(bus1.slave));
    pipe_ctrl_unit #(.ALUCTR_W(3), .RA_W(5), .FWD_EN(1'b0)) dut2 (.clk(clk), .rst(rst2), .bus(bus2.slave));

    out_t act1, act2;
    assign act1 = {bus1.stall, bus1.ifid_flush, bus1.jump, bus1.br_taken, bus1.ex_alusrc,
                   bus1.ex_aluctr, bus1.ex_extop, bus1.ex_waddr, bus1.fwd_a, bus1.fwd_b,
                   bus1.mem_memwr, bus1.wb_regwr, bus1.wb_memtoreg, bus1.wb_waddr};
    assign act2 = {bus2.stall, bus2.ifid_flush, bus2.jump, bus2.br_taken, bus2.ex_alusrc,
                   bus2.ex_aluctr, bus2.ex_extop, bus2.ex_waddr, bus2.fwd_a, bus2.fwd_b,
                   bus2.mem_memwr, bus2.wb_regwr, bus2.wb_memtoreg, bus2.wb_waddr};

    int errs = 0;
    int checks = 0;
    vec_t tbl[35];
    vec_t seq2[5];

    function automatic vec_t mk(input logic r, input logic [5:0] op, fn, input int rs, rt, rd,
                                input logic z, input logic st, fl, jp, bt, as, input int ac,
                                input logic ex, input int ew, fa, fb, input logic mw, wr, wm,
                                input int ww);
        vec_t v;
        v.rst = r;  v.op = op;  v.fn = fn;
        v.rs = 5'(rs);  v.rt = 5'(rt);  v.rd = 5'(rd);  v.z = z;
        v.exp.st = st;  v.exp.fl = fl;  v.exp.jp = jp;  v.exp.bt = bt;
        v.exp.as = as;  v.exp.ac = 3'(ac);  v.exp.ex = ex;  v.exp.ew = 5'(ew);
        v.exp.fa = 2'(fa);  v.exp.fb = 2'(fb);
        v.exp.mw = mw;  v.exp.wr = wr;  v.exp.wm = wm;  v.exp.ww = 5'(ww);
        return v;
    endfunction

    function automatic string fmt(input out_t o);
        return $sformatf("st%0b fl%0b jp%0b bt%0b as%0b ac%b ex%0b ew%0d fa%b fb%b mw%0b wr%0b wm%0b ww%0d",
                         o.st, o.fl, o.jp, o.bt, o.as, o.ac, o.ex, o.ew, o.fa, o.fb,
                         o.mw, o.wr, o.wm, o.ww);
    endfunction

    task automatic check(input string name, input out_t a, input out_t e);
        checks++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got {%s} expected {%s}", name, fmt(a), fmt(e));
        end
    endtask

    task automatic check_int(input string name, input int a, input int e);
        checks++;
        if (a != e) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, a, e);
        end
    endtask

    task automatic drive1(input vec_t v);
        rst = v.rst;  bus1.op = v.op;  bus1.func = v.fn;
        bus1.id_rs = v.rs;  bus1.id_rt = v.rt;  bus1.id_rd = v.rd;  bus1.ex_zero = v.z;
    endtask

    task automatic drive2(input vec_t v);
        rst2 = v.rst;  bus2.op = v.op;  bus2.func = v.fn;
        bus2.id_rs = v.rs;  bus2.id_rt = v.rt;  bus2.id_rd = v.rd;  bus2.ex_zero = v.z;
    endtask

    initial begin
        int stalls;
        //               rst op   fn     rs rt rd z  st fl jp bt as ac ex ew fa fb mw wr wm ww
        tbl[0]  = mk(1, R,   F_ADD, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, R,   F_ADD, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, R,   F_ADD, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, LW,  0,     0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, R,   F_ADD, 2, 4, 3, 0, 1, 0, 0, 0, 1, 0, 1, 2, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(0, R,   F_ADD, 2, 4, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3);
        tbl[6]  = mk(0, R,   F_ADD, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 1, 1, 2);
        tbl[7]  = mk(0, R,   F_SUB, 5, 5, 6, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0);
        tbl[8]  = mk(0, R,   F_ADD, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6, 2, 2, 0, 1, 0, 3);
        tbl[9]  = mk(0, R,   F_SUB, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5);
        tbl[10] = mk(0, ORI, 0,     0, 8, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7, 0, 0, 0, 1, 0, 6);
        tbl[11] = mk(0, LW,  0,     0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 8, 0, 0, 0, 1, 0, 0);
        tbl[12] = mk(0, R,   F_ADD, 0, 0, 9, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 7);
        tbl[13] = mk(0, BNE, 0,     1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 1, 0, 8);
        tbl[14] = mk(0, J,   0,     0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 2, 0, 0, 0, 1, 1, 0);
        tbl[15] = mk(0, J,   0,     0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 9);
        tbl[16] = mk(0, BEQ, 0,     3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        tbl[17] = mk(0, SW,  0,     0, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 0, 0, 0, 0);
        tbl[18] = mk(0, BAD, F_ADD, 1, 2, 3, 0, 0, 0, 0, 0, 1, 0, 1, 3, 0, 0, 0, 0, 0, 0);
        tbl[19] = mk(0, R,   F_ADD, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3);
        tbl[20] = mk(0, R,   F_ADD, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 3);
        tbl[21] = mk(0, R,   F_BAD, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        tbl[22] = mk(0, R,   F_ADD, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3);
        tbl[23] = mk(0, R,   F_ADD, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 1, 0, 3);
        tbl[24] = mk(0, R,   F_ADD, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        tbl[25] = mk(1, R,   F_ADD, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 1, 0, 3);
        tbl[26] = mk(0, R,   F_ADD, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[27] = mk(0, R,   F_ADD, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        tbl[28] = mk(0, R,   F_ADD, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0);
        tbl[29] = mk(0, R,   F_ADD, 5, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 1, 0, 3);
        tbl[30] = mk(0, R,   F_ADD, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 6, 2, 0, 0, 1, 0, 5);
        tbl[31] = mk(0, LW,  0,     0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 1, 0, 5);
        tbl[32] = mk(0, ADDI, 0,    1, 4, 0, 0, 0, 0, 0, 0, 1, 0, 1, 4, 0, 0, 0, 1, 0, 6);
        tbl[33] = mk(0, R,   F_ADD, 1, 2, 3, 0, 0, 0, 0, 0, 1, 0, 1, 4, 0, 2, 0, 1, 0, 3);
        tbl[34] = mk(0, R,   F_ADD, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 1, 1, 4);

        // Forwarding disabled: ADD $5 then SUB $6,$5,$5 held in ID while stalled.
        seq2[0] = mk(0, R,   F_ADD, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        seq2[1] = mk(0, R,   F_SUB, 5, 5, 6, 0, 1, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0);
        seq2[2] = mk(0, R,   F_SUB, 5, 5, 6, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        seq2[3] = mk(0, R,   F_SUB, 5, 5, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5);
        seq2[4] = mk(0, R,   F_ADD, 1, 2, 3, 0, 0, 0, 0, 0, 0, 1, 0, 6, 0, 0, 0, 0, 0, 0);

        drive1(tbl[0]);
        drive2(mk(1, R, F_ADD, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        stalls = 0;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk);
            #1 drive1(tbl[i]);
            @(negedge clk);
            check($sformatf("vec%0d", i), act1, tbl[i].exp);
            if (i >= 3 && i <= 6 && act1.st) stalls++;
        end
        check_int("load_use_stall_cycles", stalls, 1);

        stalls = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 drive2(seq2[i]);
            @(negedge clk);
            check($sformatf("nofwd%0d", i), act2, seq2[i].exp);
            if (act2.st) stalls++;
        end
        check_int("nofwd_raw_stall_cycles", stalls, 2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
